// File: rtl/merger_tree_p1_16in_pkg.sv
// Purpose : shared constants and helpers for the 16-input merge tree.
// Latency : n/a (package only).
// Backpr. : n/a. Contents: key width, leaf count, level count, terminator, node buffer depth.
package merger_tree_p1_16in_pkg;

    localparam int DATA_W         = 32;
    localparam int NUM_IN         = 16;
    localparam int LEVELS         = 4;
    localparam int NODE_BUF_DEPTH = 2;

    typedef logic [DATA_W-1:0] key_t;

    localparam key_t TERMINATOR = 32'd0;

    function automatic logic is_term(input key_t k);
        return (k == TERMINATOR);
    endfunction

endpackage

// File: rtl/merger_node.sv
// Purpose : 2-to-1 merge node with a 2-entry output buffer (FIFO order).
// Latency : 1 cycle from a head pop to the item appearing at out_vld_o/out_dat_o.
// Backpr. : fires only with both heads valid and buffer space (free slot or pop this cycle).
// Ports   : clk_i/rst_ni clock and async active-low reset; en_i global enable;
//           a_*/b_* left/right heads with valid and pop; out_pop_i downstream pop;
//           out_vld_o/out_dat_o buffer head.
module merger_node
    import merger_tree_p1_16in_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic a_vld_i,
    input  key_t a_dat_i,
    input  logic b_vld_i,
    input  key_t b_dat_i,
    output logic a_pop_o,
    output logic b_pop_o,
    input  logic out_pop_i,
    output logic out_vld_o,
    output key_t out_dat_o
);

    localparam logic [1:0] DEPTH = 2'(NODE_BUF_DEPTH);

    logic [1:0] cnt_q, cnt_d;
    key_t       buf0_q, buf0_d;
    key_t       buf1_q, buf1_d;
    logic       space;
    logic       fire;
    key_t       emit;

    // Merge decision: terminators act as "run exhausted" on that side, so the
    // other side drains first; a single 0 is emitted once both sides are done.
    always_comb begin
        a_pop_o = 1'b0;
        b_pop_o = 1'b0;
        emit    = TERMINATOR;
        space   = (cnt_q < DEPTH) || out_pop_i;
        fire    = en_i && a_vld_i && b_vld_i && space;
        if (fire) begin
            if (is_term(a_dat_i) && is_term(b_dat_i)) begin
                emit    = TERMINATOR;
                a_pop_o = 1'b1;
                b_pop_o = 1'b1;
            end else if (is_term(a_dat_i)) begin
                emit    = b_dat_i;
                b_pop_o = 1'b1;
            end else if (is_term(b_dat_i)) begin
                emit    = a_dat_i;
                a_pop_o = 1'b1;
            end else if (a_dat_i <= b_dat_i) begin
                // tie goes to the left head
                emit    = a_dat_i;
                a_pop_o = 1'b1;
            end else begin
                emit    = b_dat_i;
                b_pop_o = 1'b1;
            end
        end
    end

    // Two-entry buffer: buf0 is always the head. out_pop_i is only raised by
    // the consumer while out_vld_o is high.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        case ({fire, out_pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) buf0_d = emit;
                else               buf1_d = emit;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    buf0_d = emit;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = emit;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 2'd0;
            buf0_q <= TERMINATOR;
            buf1_q <= TERMINATOR;
        end else begin
            cnt_q  <= cnt_d;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
        end
    end

    assign out_vld_o = (cnt_q != 2'd0);
    assign out_dat_o = buf0_q;

endmodule

// File: rtl/merger_tree_p1_16in.sv
// Purpose : merges run k of 16 FWFT input FIFOs into one ascending run closed by a single 0.
// Latency : leaf pop at cycle t is written at t+4 at the earliest; 1 item/cycle sustained.
// Backpr. : i_fifo_out_ready=0 fills the root buffer; stalls propagate level by level, no loss.
// Ports   : i_clk, i_rst_n (async active-low); i_fifo_k/i_fifo_k_empty heads; o_fifo_k_read pops
//           (combinational); i_fifo_out_ready, o_out_fifo_write, o_data output FIFO push.
//           Optional MERGER_TREE_TERM_COUNT_EN adds o_term_count (written terminators, wraps).
module merger_tree_p1_16in
    import merger_tree_p1_16in_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_fifo_0,
    input  logic [DATA_W-1:0] i_fifo_1,
    input  logic [DATA_W-1:0] i_fifo_2,
    input  logic [DATA_W-1:0] i_fifo_3,
    input  logic [DATA_W-1:0] i_fifo_4,
    input  logic [DATA_W-1:0] i_fifo_5,
    input  logic [DATA_W-1:0] i_fifo_6,
    input  logic [DATA_W-1:0] i_fifo_7,
    input  logic [DATA_W-1:0] i_fifo_8,
    input  logic [DATA_W-1:0] i_fifo_9,
    input  logic [DATA_W-1:0] i_fifo_10,
    input  logic [DATA_W-1:0] i_fifo_11,
    input  logic [DATA_W-1:0] i_fifo_12,
    input  logic [DATA_W-1:0] i_fifo_13,
    input  logic [DATA_W-1:0] i_fifo_14,
    input  logic [DATA_W-1:0] i_fifo_15,
    input  logic              i_fifo_0_empty,
    input  logic              i_fifo_1_empty,
    input  logic              i_fifo_2_empty,
    input  logic              i_fifo_3_empty,
    input  logic              i_fifo_4_empty,
    input  logic              i_fifo_5_empty,
    input  logic              i_fifo_6_empty,
    input  logic              i_fifo_7_empty,
    input  logic              i_fifo_8_empty,
    input  logic              i_fifo_9_empty,
    input  logic              i_fifo_10_empty,
    input  logic              i_fifo_11_empty,
    input  logic              i_fifo_12_empty,
    input  logic              i_fifo_13_empty,
    input  logic              i_fifo_14_empty,
    input  logic              i_fifo_15_empty,
    input  logic              i_fifo_out_ready,
    output logic              o_fifo_0_read,
    output logic              o_fifo_1_read,
    output logic              o_fifo_2_read,
    output logic              o_fifo_3_read,
    output logic              o_fifo_4_read,
    output logic              o_fifo_5_read,
    output logic              o_fifo_6_read,
    output logic              o_fifo_7_read,
    output logic              o_fifo_8_read,
    output logic              o_fifo_9_read,
    output logic              o_fifo_10_read,
    output logic              o_fifo_11_read,
    output logic              o_fifo_12_read,
    output logic              o_fifo_13_read,
    output logic              o_fifo_14_read,
    output logic              o_fifo_15_read,
    output logic              o_out_fifo_write,
    output logic [DATA_W-1:0] o_data
`ifdef MERGER_TREE_TERM_COUNT_EN
    ,
    output logic [15:0]       o_term_count
`endif
);

    logic [NUM_IN-1:0] leaf_vld;
    logic [NUM_IN-1:0] leaf_pop;
    key_t              leaf_dat [NUM_IN];

    logic [7:0] l1_vld, l1_pop;
    key_t       l1_dat [8];
    logic [3:0] l2_vld, l2_pop;
    key_t       l2_dat [4];
    logic [1:0] l3_vld, l3_pop;
    key_t       l3_dat [2];
    logic       root_vld;
    key_t       root_dat;

    logic       run_q;
    key_t       data_q, data_d;

    assign leaf_dat[0]  = i_fifo_0;
    assign leaf_dat[1]  = i_fifo_1;
    assign leaf_dat[2]  = i_fifo_2;
    assign leaf_dat[3]  = i_fifo_3;
    assign leaf_dat[4]  = i_fifo_4;
    assign leaf_dat[5]  = i_fifo_5;
    assign leaf_dat[6]  = i_fifo_6;
    assign leaf_dat[7]  = i_fifo_7;
    assign leaf_dat[8]  = i_fifo_8;
    assign leaf_dat[9]  = i_fifo_9;
    assign leaf_dat[10] = i_fifo_10;
    assign leaf_dat[11] = i_fifo_11;
    assign leaf_dat[12] = i_fifo_12;
    assign leaf_dat[13] = i_fifo_13;
    assign leaf_dat[14] = i_fifo_14;
    assign leaf_dat[15] = i_fifo_15;

    assign leaf_vld = ~{i_fifo_15_empty, i_fifo_14_empty, i_fifo_13_empty, i_fifo_12_empty,
                        i_fifo_11_empty, i_fifo_10_empty, i_fifo_9_empty,  i_fifo_8_empty,
                        i_fifo_7_empty,  i_fifo_6_empty,  i_fifo_5_empty,  i_fifo_4_empty,
                        i_fifo_3_empty,  i_fifo_2_empty,  i_fifo_1_empty,  i_fifo_0_empty};

    assign o_fifo_0_read  = leaf_pop[0];
    assign o_fifo_1_read  = leaf_pop[1];
    assign o_fifo_2_read  = leaf_pop[2];
    assign o_fifo_3_read  = leaf_pop[3];
    assign o_fifo_4_read  = leaf_pop[4];
    assign o_fifo_5_read  = leaf_pop[5];
    assign o_fifo_6_read  = leaf_pop[6];
    assign o_fifo_7_read  = leaf_pop[7];
    assign o_fifo_8_read  = leaf_pop[8];
    assign o_fifo_9_read  = leaf_pop[9];
    assign o_fifo_10_read = leaf_pop[10];
    assign o_fifo_11_read = leaf_pop[11];
    assign o_fifo_12_read = leaf_pop[12];
    assign o_fifo_13_read = leaf_pop[13];
    assign o_fifo_14_read = leaf_pop[14];
    assign o_fifo_15_read = leaf_pop[15];

    // Nodes are held idle while reset is asserted (and for the first edge after
    // release) so no combinational leaf pop escapes while state cannot advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) run_q <= 1'b0;
        else          run_q <= 1'b1;
    end

    for (genvar j = 0; j < 8; j++) begin : g_l1
        merger_node u_node (
            .clk_i(i_clk), .rst_ni(i_rst_n), .en_i(run_q),
            .a_vld_i(leaf_vld[2*j]),   .a_dat_i(leaf_dat[2*j]),
            .b_vld_i(leaf_vld[2*j+1]), .b_dat_i(leaf_dat[2*j+1]),
            .a_pop_o(leaf_pop[2*j]),   .b_pop_o(leaf_pop[2*j+1]),
            .out_pop_i(l1_pop[j]), .out_vld_o(l1_vld[j]), .out_dat_o(l1_dat[j])
        );
    end

    for (genvar j = 0; j < 4; j++) begin : g_l2
        merger_node u_node (
            .clk_i(i_clk), .rst_ni(i_rst_n), .en_i(run_q),
            .a_vld_i(l1_vld[2*j]),   .a_dat_i(l1_dat[2*j]),
            .b_vld_i(l1_vld[2*j+1]), .b_dat_i(l1_dat[2*j+1]),
            .a_pop_o(l1_pop[2*j]),   .b_pop_o(l1_pop[2*j+1]),
            .out_pop_i(l2_pop[j]), .out_vld_o(l2_vld[j]), .out_dat_o(l2_dat[j])
        );
    end

    for (genvar j = 0; j < 2; j++) begin : g_l3
        merger_node u_node (
            .clk_i(i_clk), .rst_ni(i_rst_n), .en_i(run_q),
            .a_vld_i(l2_vld[2*j]),   .a_dat_i(l2_dat[2*j]),
            .b_vld_i(l2_vld[2*j+1]), .b_dat_i(l2_dat[2*j+1]),
            .a_pop_o(l2_pop[2*j]),   .b_pop_o(l2_pop[2*j+1]),
            .out_pop_i(l3_pop[j]), .out_vld_o(l3_vld[j]), .out_dat_o(l3_dat[j])
        );
    end

    merger_node u_root (
        .clk_i(i_clk), .rst_ni(i_rst_n), .en_i(run_q),
        .a_vld_i(l3_vld[0]), .a_dat_i(l3_dat[0]),
        .b_vld_i(l3_vld[1]), .b_dat_i(l3_dat[1]),
        .a_pop_o(l3_pop[0]), .b_pop_o(l3_pop[1]),
        .out_pop_i(o_out_fifo_write), .out_vld_o(root_vld), .out_dat_o(root_dat)
    );

    assign o_out_fifo_write = root_vld && i_fifo_out_ready;

    // o_data follows the root head; when the root is empty it keeps the last head seen.
    assign data_d = root_vld ? root_dat : data_q;
    assign o_data = data_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) data_q <= TERMINATOR;
        else          data_q <= data_d;
    end

`ifdef MERGER_TREE_TERM_COUNT_EN
    logic [15:0] term_cnt_q, term_cnt_d;

    // 16-bit add wraps 65535 -> 0 on its own.
    assign term_cnt_d = (o_out_fifo_write && is_term(root_dat)) ? term_cnt_q + 16'd1 : term_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) term_cnt_q <= 16'd0;
        else          term_cnt_q <= term_cnt_d;
    end

    assign o_term_count = term_cnt_q;
`else
    // Terminator counter not built.
`endif

endmodule

// File: tb/tb_merger_tree_p1_16in.sv
// Purpose : self-checking bench for merger_tree_p1_16in with modelled FWFT input FIFOs.
// Latency : checks first-write latency of 4 cycles and gap-free streaming.
// Backpr. : exercises a 10-cycle output stall and a starved input.
module tb_merger_tree_p1_16in;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fifo_dat [16];
    logic [15:0] fifo_emp;
    logic        out_rdy;
    logic [15:0] rd;
    logic        wr;
    logic [31:0] dout;
`ifdef MERGER_TREE_TERM_COUNT_EN
    logic [15:0] term_count;
`endif

    logic [31:0] inq [16][$];
    logic [31:0] exp_q [$];
    logic [15:0] rd_s;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pop_cnt [16];
    int first_rd = -1, first_wr = -1, last_wr = -1, gaps = 0, wr_cnt = 0;

    always #5 clk = ~clk;

    merger_tree_p1_16in dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fifo_0(fifo_dat[0]),   .i_fifo_1(fifo_dat[1]),   .i_fifo_2(fifo_dat[2]),   .i_fifo_3(fifo_dat[3]),
        .i_fifo_4(fifo_dat[4]),   .i_fifo_5(fifo_dat[5]),   .i_fifo_6(fifo_dat[6]),   .i_fifo_7(fifo_dat[7]),
        .i_fifo_8(fifo_dat[8]),   .i_fifo_9(fifo_dat[9]),   .i_fifo_10(fifo_dat[10]), .i_fifo_11(fifo_dat[11]),
        .i_fifo_12(fifo_dat[12]), .i_fifo_13(fifo_dat[13]), .i_fifo_14(fifo_dat[14]), .i_fifo_15(fifo_dat[15]),
        .i_fifo_0_empty(fifo_emp[0]),   .i_fifo_1_empty(fifo_emp[1]),   .i_fifo_2_empty(fifo_emp[2]),
        .i_fifo_3_empty(fifo_emp[3]),   .i_fifo_4_empty(fifo_emp[4]),   .i_fifo_5_empty(fifo_emp[5]),
        .i_fifo_6_empty(fifo_emp[6]),   .i_fifo_7_empty(fifo_emp[7]),   .i_fifo_8_empty(fifo_emp[8]),
        .i_fifo_9_empty(fifo_emp[9]),   .i_fifo_10_empty(fifo_emp[10]), .i_fifo_11_empty(fifo_emp[11]),
        .i_fifo_12_empty(fifo_emp[12]), .i_fifo_13_empty(fifo_emp[13]), .i_fifo_14_empty(fifo_emp[14]),
        .i_fifo_15_empty(fifo_emp[15]),
        .i_fifo_out_ready(out_rdy),
        .o_fifo_0_read(rd[0]),   .o_fifo_1_read(rd[1]),   .o_fifo_2_read(rd[2]),   .o_fifo_3_read(rd[3]),
        .o_fifo_4_read(rd[4]),   .o_fifo_5_read(rd[5]),   .o_fifo_6_read(rd[6]),   .o_fifo_7_read(rd[7]),
        .o_fifo_8_read(rd[8]),   .o_fifo_9_read(rd[9]),   .o_fifo_10_read(rd[10]), .o_fifo_11_read(rd[11]),
        .o_fifo_12_read(rd[12]), .o_fifo_13_read(rd[13]), .o_fifo_14_read(rd[14]), .o_fifo_15_read(rd[15]),
        .o_out_fifo_write(wr),
        .o_data(dout)
`ifdef MERGER_TREE_TERM_COUNT_EN
        , .o_term_count(term_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // FWFT model: head on the data port, garbage when empty so a bad read would show.
    task automatic drive();
        for (int k = 0; k < 16; k++) begin
            fifo_emp[k] = (inq[k].size() == 0);
            fifo_dat[k] = fifo_emp[k] ? 32'hFFFF_FFFF : inq[k][0];
        end
    endtask

    task automatic push(input int k, input logic [31:0] v);
        inq[k].push_back(v);
        drive();
    endtask

    task automatic at_edge();
        @(posedge clk);
        #3;
    endtask

    task automatic clear_stats();
        first_rd = -1; first_wr = -1; last_wr = -1; gaps = 0; wr_cnt = 0;
    endtask

    function automatic bit inputs_empty();
        for (int k = 0; k < 16; k++) if (inq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !inputs_empty()) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (10) @(posedge clk);
        check({name, "_drain_left"}, exp_q.size(), 0);
        check({name, "_timeout"}, (n >= 2000) ? 1 : 0, 0);
    endtask

    // Input FIFO pops: reads sampled on the previous falling edge are applied just after the rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        for (int k = 0; k < 16; k++) begin
            if (rd_s[k] && inq[k].size() != 0) begin
                void'(inq[k].pop_front());
                pop_cnt[k]++;
            end
        end
        drive();
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        rd_s = rd;
        if (rst_n) begin
            if (rd != 16'd0) begin
                check("read_while_empty", {16'd0, rd & fifo_emp}, 32'd0);
                if (first_rd < 0) first_rd = cyc;
            end
            if (!out_rdy) check("write_during_stall", {31'd0, wr}, 32'd0);
            if (wr) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
                if (last_wr >= 0 && cyc != last_wr + 1) gaps++;
                last_wr = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0d expected no write", dout);
                end else begin
                    check("out_data", dout, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int b;
        int held;
        out_rdy = 1'b1;
        rd_s = '0;
        for (int k = 0; k < 16; k++) pop_cnt[k] = 0;
        drive();

        // Reset with data already present: nothing may be read or written.
        at_edge();
        for (int k = 0; k < 16; k++) push(k, 32'd0);
        @(negedge clk);
        check("rst_write", {31'd0, wr}, 32'd0);
        check("rst_data", dout, 32'd0);
        check("rst_reads", {16'd0, rd}, 32'd0);

        // Empty run
        at_edge();
        rst_n = 1'b1;
        exp_q.push_back(32'd0);
        wait_drain("empty_run");
        for (int k = 0; k < 16; k++) check($sformatf("empty_run_pops_%0d", k), pop_cnt[k], 1);

        // Single run with leading empty run
        at_edge();
        clear_stats();
        for (int k = 0; k < 16; k++) begin
            b = (k == 1) ? 3 : (k == 2) ? 2 : k + 1;
            push(k, 32'd0);
            push(k, b);
            push(k, b + 16);
            push(k, 33 + k);
            push(k, 32'd0);
        end
        exp_q.push_back(32'd0);
        for (int v = 1; v <= 48; v++) exp_q.push_back(v);
        exp_q.push_back(32'd0);
        wait_drain("single_run");
        check("single_run_latency", first_wr - first_rd, 4);
        check("single_run_gaps", gaps, 0);
        check("single_run_count", wr_cnt, 50);

        // Trailing empty runs
        at_edge();
        clear_stats();
        for (int k = 0; k < 16; k++) for (int r = 0; r < 12; r++) push(k, 32'd0);
        for (int r = 0; r < 12; r++) exp_q.push_back(32'd0);
        wait_drain("trailing");
        check("trailing_count", wr_cnt, 12);

        // Backpressure mid-stream
        at_edge();
        clear_stats();
        for (int k = 0; k < 16; k++) begin
            push(k, 100 + k);
            push(k, 200 + k);
            push(k, 32'd0);
        end
        for (int k = 0; k < 16; k++) exp_q.push_back(100 + k);
        for (int k = 0; k < 16; k++) exp_q.push_back(200 + k);
        exp_q.push_back(32'd0);
        begin
            int n = 0;
            while (wr_cnt < 5 && n < 200) begin
                @(posedge clk);
                n++;
            end
        end
        #3;
        out_rdy = 1'b0;
        held = wr_cnt;
        repeat (10) @(posedge clk);
        #3;
        check("stall_no_progress", wr_cnt, held);
        out_rdy = 1'b1;
        wait_drain("backpressure");
        check("backpressure_count", wr_cnt, 33);

        // Ties and uneven runs
        at_edge();
        clear_stats();
        push(0, 5); push(0, 5); push(0, 0);
        push(1, 5); push(1, 0);
        for (int k = 2; k < 16; k++) push(k, 32'd0);
        exp_q.push_back(5); exp_q.push_back(5); exp_q.push_back(5); exp_q.push_back(0);
        @(negedge clk);
        check("tie_pops_left", {30'd0, rd[1:0]}, 32'd1);
        wait_drain("ties");
        check("ties_count", wr_cnt, 4);

        // Starved input 7
        at_edge();
        clear_stats();
        for (int k = 0; k < 16; k++) begin
            if (k != 7) begin
                push(k, 300 + k);
                push(k, 32'd0);
            end
        end
        for (int k = 0; k < 16; k++) exp_q.push_back(300 + k);
        exp_q.push_back(32'd0);
        repeat (20) @(posedge clk);
        #3;
        check("starve_hold", (wr_cnt <= 7) ? 1 : 0, 1);
        push(7, 307);
        push(7, 32'd0);
        wait_drain("starved");
        check("starved_count", wr_cnt, 17);

`ifdef MERGER_TREE_TERM_COUNT_EN
        check("term_count", {16'd0, term_count}, 32'd18);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
